// File: rtl/usb_rx_phy_pkg.sv
// Shared types and constants for the low-speed USB receive path.
// CLK_PER_BIT is also meant for the future transmit path.
package usb_rx_phy_pkg;

  localparam int unsigned CLK_PER_BIT = 16;
  localparam int unsigned PHASE_W     = $clog2(CLK_PER_BIT);

  // Encoding matches the raw pad pair {d_p, d_n} at low speed.
  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_J   = 2'b01,
    LS_K   = 2'b10,
    LS_SE1 = 2'b11
  } line_state_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP,
    ST_ABORT
  } rx_state_t;

  // SE1 is illegal on the bus and is handled exactly like SE0.
  function automatic logic ls_is_se0(line_state_t ls);
    return (ls == LS_SE0) || (ls == LS_SE1);
  endfunction

endpackage

// File: rtl/usb_rx_phy_if.sv
// Receive-side bus from the PHY to the serial interface engine.
interface usb_rx_phy_if;
  logic [7:0] rx_data;
  logic       rx_active;
  logic       rx_valid;
  logic       rx_error;
  logic       bus_reset;

  modport master (output rx_data, output rx_active, output rx_valid,
                  output rx_error, output bus_reset);
  modport slave  (input rx_data, input rx_active, input rx_valid,
                  input rx_error, input bus_reset);
endinterface

// File: rtl/usb_rx_dpll.sv
// Pad synchroniser, line-state decode and bit-phase recovery.
// sample_en pulses in the cycle whose line_state is the bit-centre sample.
module usb_rx_dpll
  import usb_rx_phy_pkg::*;
#(
  parameter int unsigned SAMPLE_PHASE = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_p,
  input  logic        d_n,
  output line_state_t line_state,
  output logic        sample_en
);

  logic [1:0]         sync1_q, sync2_q;
  line_state_t        ls_raw;
  logic [PHASE_W-1:0] phase_q, phase_nxt;

  assign ls_raw = line_state_t'(sync2_q);

  // Re-align the phase on every line edge; otherwise free-run and wrap.
  always_comb begin
    phase_nxt = phase_q + PHASE_W'(1);
    if (ls_raw != line_state) begin
      phase_nxt = '0;
    end else if (phase_q == PHASE_W'(CLK_PER_BIT - 1)) begin
      phase_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= 2'b01;
      sync2_q    <= 2'b01;
      line_state <= LS_J;
      phase_q    <= '0;
      sample_en  <= 1'b0;
    end else begin
      sync1_q    <= {d_p, d_n};
      sync2_q    <= sync1_q;
      line_state <= ls_raw;
      phase_q    <= phase_nxt;
      sample_en  <= (phase_nxt == PHASE_W'(SAMPLE_PHASE));
    end
  end

endmodule

// File: rtl/usb_rx_phy.sv
// Low-speed USB receive front end: NRZI decode, bit unstuffing,
// SYNC/EOP framing, byte assembly and bus-reset detection.
module usb_rx_phy
  import usb_rx_phy_pkg::*;
#(
  parameter int unsigned SAMPLE_PHASE = 7,
  parameter int unsigned RESET_CYCLES = 60
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         d_p,
  input  logic         d_n,
  usb_rx_phy_if.master rx
);

  localparam int unsigned SE0_W = $clog2(RESET_CYCLES + 1);

  line_state_t line_state;
  logic        sample_en;

  usb_rx_dpll #(
    .SAMPLE_PHASE(SAMPLE_PHASE)
  ) u_dpll (
    .clk       (clk),
    .reset     (reset),
    .d_p       (d_p),
    .d_n       (d_n),
    .line_state(line_state),
    .sample_en (sample_en)
  );

  rx_state_t        state_q, state_nxt;
  line_state_t      prev_q, prev_nxt;
  logic [1:0]       zeros_q, zeros_nxt;
  logic [2:0]       ones_q, ones_nxt;
  logic [2:0]       bit_cnt_q, bit_cnt_nxt;
  logic [6:0]       shift_q, shift_nxt;
  logic [7:0]       data_q, data_nxt;
  logic             active_q, active_nxt;
  logic             valid_q, valid_nxt;
  logic             error_q, error_nxt;
  logic             bus_reset_q, bus_reset_nxt;
  logic [SE0_W-1:0] se0_cnt_q, se0_cnt_nxt;
  logic             is_se0;
  logic             nrzi_bit;

  assign is_se0   = ls_is_se0(line_state);
  // A repeated J/K level is a 1; the reference level is J while idle.
  assign nrzi_bit = (line_state == ((state_q == ST_IDLE) ? LS_J : prev_q));

  // Saturating count of consecutive SE0 clocks.
  always_comb begin
    se0_cnt_nxt = '0;
    if (is_se0) begin
      se0_cnt_nxt = (se0_cnt_q == SE0_W'(RESET_CYCLES)) ? se0_cnt_q
                                                        : se0_cnt_q + SE0_W'(1);
    end
    bus_reset_nxt = (se0_cnt_nxt == SE0_W'(RESET_CYCLES));
  end

  always_comb begin
    state_nxt   = state_q;
    prev_nxt    = prev_q;
    zeros_nxt   = zeros_q;
    ones_nxt    = ones_q;
    bit_cnt_nxt = bit_cnt_q;
    shift_nxt   = shift_q;
    data_nxt    = data_q;
    active_nxt  = active_q;
    valid_nxt   = 1'b0;
    error_nxt   = 1'b0;

    if (sample_en && !is_se0) begin
      prev_nxt = line_state;
    end

    if (sample_en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (line_state == LS_K) begin
            state_nxt = ST_SYNC;
            zeros_nxt = '0;
          end
        end
        ST_SYNC: begin
          if (is_se0) begin
            state_nxt = ST_IDLE;
          end else if (!nrzi_bit) begin
            zeros_nxt = (zeros_q == 2'd3) ? zeros_q : zeros_q + 2'd1;
          end else if (zeros_q == 2'd3) begin
            state_nxt   = ST_DATA;
            active_nxt  = 1'b1;
            bit_cnt_nxt = '0;
            ones_nxt    = '0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_DATA: begin
          if (is_se0) begin
            active_nxt = 1'b0;
            if (bit_cnt_q == 3'd0) begin
              state_nxt = ST_EOP;
            end else begin
              state_nxt = ST_ABORT;
              error_nxt = 1'b1;
            end
          end else if (ones_q == 3'd6) begin
            // Stuff bit slot: a 0 is discarded, a 1 breaks the stuffing rule.
            if (!nrzi_bit) begin
              ones_nxt = '0;
            end else begin
              state_nxt  = ST_ABORT;
              active_nxt = 1'b0;
              error_nxt  = 1'b1;
            end
          end else begin
            shift_nxt   = {nrzi_bit, shift_q[6:1]};
            ones_nxt    = nrzi_bit ? ones_q + 3'd1 : 3'd0;
            bit_cnt_nxt = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              data_nxt  = {nrzi_bit, shift_q};
              valid_nxt = 1'b1;
            end
          end
        end
        ST_EOP, ST_ABORT: begin
          if (line_state == LS_J) begin
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end

    if (bus_reset_q) begin
      state_nxt  = ST_IDLE;
      active_nxt = 1'b0;
      valid_nxt  = 1'b0;
      error_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      prev_q      <= LS_J;
      zeros_q     <= '0;
      ones_q      <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= 8'h00;
      active_q    <= 1'b0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      bus_reset_q <= 1'b0;
      se0_cnt_q   <= '0;
    end else begin
      state_q     <= state_nxt;
      prev_q      <= prev_nxt;
      zeros_q     <= zeros_nxt;
      ones_q      <= ones_nxt;
      bit_cnt_q   <= bit_cnt_nxt;
      shift_q     <= shift_nxt;
      data_q      <= data_nxt;
      active_q    <= active_nxt;
      valid_q     <= valid_nxt;
      error_q     <= error_nxt;
      bus_reset_q <= bus_reset_nxt;
      se0_cnt_q   <= se0_cnt_nxt;
    end
  end

  assign rx.rx_data   = data_q;
  assign rx.rx_active = active_q;
  assign rx.rx_valid  = valid_q;
  assign rx.rx_error  = error_q;
  assign rx.bus_reset = bus_reset_q;

endmodule

// File: tb/tb_usb_rx_phy.sv
// Randomised packet bench for usb_rx_phy: a wire-level transmitter plus a
// byte/error scoreboard derived from the packets that were sent.
module tb_usb_rx_phy;

  localparam logic [1:0] LJ   = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic d_p = 1'b0;
  logic d_n = 1'b1;

  usb_rx_phy_if rx();

  usb_rx_phy dut (
    .clk  (clk),
    .reset(reset),
    .d_p  (d_p),
    .d_n  (d_n),
    .rx   (rx)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         err_seen = 0;
  bit         saw_active = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] pkt[$];
  bit         wire_bits[$];
  bit         jitter = 1'b0;
  bit         jit_long = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Scoreboard: every received byte must be the next one the model expects.
  always @(negedge clk) begin
    if (reset) begin
      check("valid_error_overlap", 32'(rx.rx_valid & rx.rx_error), 32'd0);
      if (rx.rx_valid) begin
        check("valid_while_active", 32'(rx.rx_active), 32'd1);
        if (exp_q.size() == 0) check("extra_byte", 32'(rx.rx_valid), 32'd0);
        else check("rx_data", 32'(rx.rx_data), 32'(exp_q.pop_front()));
      end
      if (rx.rx_error) err_seen++;
      if (rx.rx_active) saw_active = 1'b1;
    end
  end

  task automatic drive(input logic [1:0] lv, input int n);
    {d_p, d_n} = lv;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Nominal 16 clocks; with jitter the period alternates 15/17.
  task automatic bit_len(output int n);
    if (!jitter) n = 16;
    else begin
      jit_long = ~jit_long;
      n = jit_long ? 17 : 15;
    end
  endtask

  function automatic logic [1:0] flip(input logic [1:0] lv);
    return (lv == LJ) ? 2'b10 : LJ;
  endfunction

  // mode 0: stuffed bytes; 1: first byte then seven raw 1s; 2: first trunc bits only.
  task automatic build(input int mode, input int trunc);
    int ones = 0;
    int cnt = 0;
    bit b;
    wire_bits.delete();
    for (int i = 0; i < pkt.size(); i++) begin
      for (int k = 0; k < 8; k++) begin
        if (mode == 2 && cnt == trunc) return;
        b = pkt[i][k];
        wire_bits.push_back(b);
        cnt++;
        ones = b ? ones + 1 : 0;
        if (ones == 6) begin
          wire_bits.push_back(1'b0);
          ones = 0;
        end
      end
      if (mode == 1) begin
        repeat (7) wire_bits.push_back(1'b1);
        return;
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_data"},   32'(rx.rx_data),   32'd0);
    check({tag, "_rx_active"}, 32'(rx.rx_active), 32'd0);
    check({tag, "_rx_valid"},  32'(rx.rx_valid),  32'd0);
    check({tag, "_rx_error"},  32'(rx.rx_error),  32'd0);
    check({tag, "_bus_reset"}, 32'(rx.bus_reset), 32'd0);
  endtask

  // SYNC, the NRZI-encoded wire bits, EOP, then idle J. abort_bit >= 0 pulls reset mid-bit.
  task automatic transmit(input int abort_bit);
    logic [1:0] lv;
    int n;
    lv = LJ;
    for (int i = 0; i < 8; i++) begin
      if (i < 7) lv = flip(lv);
      bit_len(n);
      drive(lv, n);
    end
    for (int i = 0; i < wire_bits.size(); i++) begin
      if (!wire_bits[i]) lv = flip(lv);
      if (i == abort_bit) begin
        {d_p, d_n} = lv;
        repeat (8) @(posedge clk);
        #3 reset = 1'b0;
        #1 check_reset_values("async_reset");
        return;
      end
      bit_len(n);
      drive(lv, n);
    end
    bit_len(n);
    drive(LSE0, n);
    bit_len(n);
    drive(LSE0, n);
    drive(LJ, 48);
  endtask

  task automatic run_packet(input string name, input int mode, input int trunc, input int exp_err);
    err_seen = 0;
    saw_active = 1'b0;
    build(mode, trunc);
    transmit(-1);
    check({name, "_errors"},     32'(err_seen),     32'(exp_err));
    check({name, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_active_low"}, 32'(rx.rx_active), 32'd0);
    check({name, "_saw_active"}, 32'(saw_active),   32'd1);
    exp_q.delete();
  endtask

  task automatic random_pkt(input int nbytes);
    pkt.delete();
    for (int i = 0; i < nbytes; i++) pkt.push_back(8'($urandom));
  endtask

  initial begin
    int n;
    repeat (5) @(posedge clk);
    #1 check_reset_values("reset");
    reset = 1'b1;
    drive(LJ, 64);

    // Two plain bytes; no stuffing needed.
    pkt = '{8'hA5, 8'h69};
    build(0, 0);
    check("wire_len_a5_69", 32'(wire_bits.size()), 32'd16);
    exp_q = '{8'hA5, 8'h69};
    run_packet("pkt_a5_69", 0, 0, 0);

    // Runs of ones force two stuffed zeros.
    pkt = '{8'hFF, 8'h3F};
    build(0, 0);
    check("wire_len_ff_3f", 32'(wire_bits.size()), 32'd18);
    exp_q = '{8'hFF, 8'h3F};
    run_packet("pkt_ff_3f", 0, 0, 0);

    // Missing stuff bit: first byte arrives, then exactly one error.
    random_pkt(2);
    exp_q.push_back(pkt[0]);
    run_packet("stuff_error", 1, 0, 1);

    // EOP after five data bits.
    random_pkt(1);
    run_packet("short_eop", 2, 5, 1);

    // Jittered bit periods.
    jitter = 1'b1;
    for (int r = 0; r < 4; r++) begin
      random_pkt(3);
      foreach (pkt[i]) exp_q.push_back(pkt[i]);
      run_packet("jitter_pkt", 0, 0, 0);
    end

    // Mixed random packets.
    for (int r = 0; r < 6; r++) begin
      jitter = 1'($urandom_range(1, 0));
      random_pkt(int'($urandom_range(4, 1)));
      foreach (pkt[i]) exp_q.push_back(pkt[i]);
      run_packet("random_pkt", 0, 0, 0);
    end
    jitter = 1'b0;

    // Long SE0: rise after 2 sync stages + registered line state + 60 SE0 clocks.
    err_seen = 0;
    {d_p, d_n} = LSE0;
    n = 0;
    while (n < 200 && !rx.bus_reset) begin
      @(posedge clk);
      #1 n++;
    end
    check("bus_reset_rise_clk", 32'(n), 32'd63);
    repeat (100 - n) @(posedge clk);
    #1 check("bus_reset_held", 32'(rx.bus_reset), 32'd1);
    {d_p, d_n} = LJ;
    n = 0;
    while (n < 50 && rx.bus_reset) begin
      @(posedge clk);
      #1 n++;
    end
    check("bus_reset_fall_clk", 32'(n), 32'd4);
    check("bus_reset_no_error", 32'(err_seen), 32'd0);
    drive(LJ, 64);

    // Asynchronous reset inside the second byte.
    random_pkt(3);
    exp_q.push_back(pkt[0]);
    err_seen = 0;
    build(0, 0);
    transmit(12);
    {d_p, d_n} = LJ;
    repeat (4) @(posedge clk);
    #1 check_reset_values("reset_held");
    reset = 1'b1;
    drive(LJ, 64);
    check("abort_first_byte_seen", 32'(exp_q.size()), 32'd0);
    check("abort_no_error", 32'(err_seen), 32'd0);
    exp_q.delete();

    // Receiver recovers for the next packet.
    random_pkt(3);
    foreach (pkt[i]) exp_q.push_back(pkt[i]);
    run_packet("after_reset", 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
